// File: rtl/mem_arbiter_id_if.sv
// Line-transaction port between a cache (or the arbiter) and a memory.
// master issues read/write/addr/wdata; slave answers with rdata/ready.
interface mem_arbiter_id_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output read, write, addr, wdata, input rdata, ready);
  modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter_id.sv
// Shares one line-wide memory port between the Icache and Dcache,
// one transaction at a time, by fixed Dcache priority or round-robin.
module mem_arbiter_id #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter int D_PRIORITY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_id_if.slave   i_bus,
  mem_arbiter_id_if.slave   d_bus,
  mem_arbiter_id_if.master  mem_bus,
  output logic              grant_d,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

  state_t            state, next_state;
  logic              last_grant_d;
  logic              req_i, req_d, pick_d;
  logic              rd_q, wr_q, grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Round-robin hands a tie to whichever cache was not served last.
  always_comb begin
    req_i = i_bus.read | i_bus.write;
    req_d = d_bus.read | d_bus.write;
    if (D_PRIORITY != 0) pick_d = req_d;
    else                 pick_d = req_d & (~req_i | ~last_grant_d);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pick_d)     next_state = BUSY_D;
        else if (req_i) next_state = BUSY_I;
      end
      BUSY_I, BUSY_D: if (mem_bus.ready) next_state = RELEASE;
      RELEASE:        next_state = IDLE;
      default:        next_state = IDLE;
    endcase
  end

  // Winner's request is latched on the grant edge and held until memory answers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      grant_q      <= 1'b0;
      last_grant_d <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (next_state == BUSY_D) begin
            rd_q         <= d_bus.read;
            wr_q         <= d_bus.write;
            addr_q       <= d_bus.addr;
            wdata_q      <= d_bus.wdata;
            grant_q      <= 1'b1;
            last_grant_d <= 1'b1;
          end else if (next_state == BUSY_I) begin
            rd_q         <= i_bus.read;
            wr_q         <= i_bus.write;
            addr_q       <= i_bus.addr;
            wdata_q      <= i_bus.wdata;
            grant_q      <= 1'b0;
            last_grant_d <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_bus.ready) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            grant_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = (state != IDLE);
    grant_d     = grant_q;
    i_bus.ready = mem_bus.ready & (state == BUSY_I);
    d_bus.ready = mem_bus.ready & (state == BUSY_D);
  end

  assign i_bus.rdata   = mem_bus.rdata;
  assign d_bus.rdata   = mem_bus.rdata;
  assign mem_bus.read  = rd_q;
  assign mem_bus.write = wr_q;
  assign mem_bus.addr  = addr_q;
  assign mem_bus.wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter_id.sv
// Scoreboard bench for mem_arbiter_id: a fixed-priority and a round-robin
// instance share one stimulus/memory-responder set selected by 'sel'.
module tb_mem_arbiter_id;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, sel;
  logic         i_read, i_write, d_read, d_write, mem_ready;
  logic [27:0]  i_addr, d_addr;
  logic [127:0] i_wdata, d_wdata, mem_rdata;
  int           n_checks = 0;
  int           n_fail = 0;

  typedef struct {
    bit           is_d;
    bit           rd;
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } exp_t;
  exp_t exp_q[$];

  mem_arbiter_id_if #(.ADDR_W(28), .DATA_W(128)) ip(), dp(), mp(), ir(), dr(), mr();
  logic grant_d_p, busy_p, grant_d_r, busy_r;

  mem_arbiter_id #(.ADDR_W(28), .DATA_W(128), .D_PRIORITY(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .i_bus(ip), .d_bus(dp), .mem_bus(mp),
    .grant_d(grant_d_p), .busy(busy_p));

  mem_arbiter_id #(.ADDR_W(28), .DATA_W(128), .D_PRIORITY(0)) dut_r (
    .clk(clk), .rst_n(rst_n), .i_bus(ir), .d_bus(dr), .mem_bus(mr),
    .grant_d(grant_d_r), .busy(busy_r));

  assign ip.read  = sel ? 1'b0 : i_read;
  assign ip.write = sel ? 1'b0 : i_write;
  assign ip.addr  = i_addr;
  assign ip.wdata = i_wdata;
  assign dp.read  = sel ? 1'b0 : d_read;
  assign dp.write = sel ? 1'b0 : d_write;
  assign dp.addr  = d_addr;
  assign dp.wdata = d_wdata;
  assign mp.rdata = mem_rdata;
  assign mp.ready = sel ? 1'b0 : mem_ready;
  assign ir.read  = sel ? i_read : 1'b0;
  assign ir.write = sel ? i_write : 1'b0;
  assign ir.addr  = i_addr;
  assign ir.wdata = i_wdata;
  assign dr.read  = sel ? d_read : 1'b0;
  assign dr.write = sel ? d_write : 1'b0;
  assign dr.addr  = d_addr;
  assign dr.wdata = d_wdata;
  assign mr.rdata = mem_rdata;
  assign mr.ready = sel ? mem_ready : 1'b0;

  logic         o_mem_read, o_mem_write, o_i_ready, o_d_ready, o_grant_d, o_busy;
  logic [27:0]  o_mem_addr;
  logic [127:0] o_mem_wdata, o_i_rdata, o_d_rdata;
  assign o_mem_read  = sel ? mr.read  : mp.read;
  assign o_mem_write = sel ? mr.write : mp.write;
  assign o_mem_addr  = sel ? mr.addr  : mp.addr;
  assign o_mem_wdata = sel ? mr.wdata : mp.wdata;
  assign o_i_ready   = sel ? ir.ready : ip.ready;
  assign o_d_ready   = sel ? dr.ready : dp.ready;
  assign o_i_rdata   = sel ? ir.rdata : ip.rdata;
  assign o_d_rdata   = sel ? dr.rdata : dp.rdata;
  assign o_grant_d   = sel ? grant_d_r : grant_d_p;
  assign o_busy      = sel ? busy_r : busy_p;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Raises a cache request and records the memory transaction it should produce.
  task automatic applyStimulus(input bit is_d, input bit rd, input bit wr,
                               input logic [27:0] addr, input logic [127:0] wdata);
    exp_t e;
    if (is_d) begin
      d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      i_read = rd; i_write = wr; i_addr = addr; i_wdata = wdata;
    end
    e.is_d = is_d; e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  // Acts as memory for one transaction; returns at the RELEASE-cycle negedge.
  task automatic serveMem(input int exp_wait, input int lat, input logic [127:0] rdata);
    int   waited;
    exp_t e;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(o_mem_read || o_mem_write) && waited < 50);
    checkOutput("grant_latency", waited, exp_wait);
    checkOutput("sb_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    checkOutput("mem_read", o_mem_read, e.rd);
    checkOutput("mem_write", o_mem_write, e.wr);
    checkOutput("mem_addr", o_mem_addr, e.addr);
    checkOutput("mem_wdata", o_mem_wdata, e.wdata);
    checkOutput("grant_d", o_grant_d, e.is_d);
    checkOutput("busy_owned", o_busy, 1);
    repeat (lat - 1) @(negedge clk);
    checkOutput("mem_addr_hold", o_mem_addr, e.addr);
    checkOutput("mem_read_hold", o_mem_read, e.rd);
    mem_rdata = rdata;
    mem_ready = 1'b1;
    #1;
    checkOutput("i_ready", o_i_ready, !e.is_d);
    checkOutput("d_ready", o_d_ready, e.is_d);
    checkOutput("rdata", e.is_d ? o_d_rdata : o_i_rdata, rdata);
    @(negedge clk);
    mem_ready = 1'b0;
    if (e.is_d) begin d_read = 1'b0; d_write = 1'b0; end
    else        begin i_read = 1'b0; i_write = 1'b0; end
    #1;
    checkOutput("release_busy", o_busy, 1);
    checkOutput("release_rd", o_mem_read, 0);
    checkOutput("release_wr", o_mem_write, 0);
    checkOutput("release_ready", {o_i_ready, o_d_ready}, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sel = 1'b0; rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;

    // Reset held with a Dcache request pending.
    applyStimulus(1, 1, 0, 28'h0000ABC, '0);
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_read", o_mem_read, 0);
    checkOutput("rst_mem_write", o_mem_write, 0);
    checkOutput("rst_mem_addr", o_mem_addr, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_grant_d", o_grant_d, 0);
    rst_n = 1'b1;
    serveMem(1, 3, {4{32'hCAFE0001}});
    @(negedge clk);
    checkOutput("idle_busy", o_busy, 0);

    applyStimulus(0, 1, 0, 28'h0000010, '0);
    serveMem(1, 8, {16{8'hA5}});
    @(negedge clk);
    checkOutput("idle_busy", o_busy, 0);

    applyStimulus(1, 0, 1, 28'h0000100, 128'h1234);
    serveMem(1, 5, 128'h0);
    @(negedge clk);
    checkOutput("idle_busy", o_busy, 0);

    // Simultaneous requests: Dcache wins, Icache follows after RELEASE/IDLE.
    applyStimulus(1, 1, 0, 28'h0000200, '0);
    applyStimulus(0, 1, 0, 28'h0000300, '0);
    serveMem(1, 4, {4{32'hD0D0D0D0}});
    serveMem(2, 3, {4{32'h1C1C1C1C}});
    @(negedge clk);

    applyStimulus(0, 1, 1, 28'h0FFFFFF, {4{32'hFFFFFFFF}});
    serveMem(1, 2, 128'h77);
    @(negedge clk);

    // Abort an Icache transaction with reset, then send a stray mem_ready.
    i_read = 1'b1; i_addr = 28'h0000400;
    @(negedge clk);
    checkOutput("abort_granted", o_mem_read, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; i_read = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("abort_mem_read", o_mem_read, 0);
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_i_ready", o_i_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rdata = {4{32'hBAD0BAD0}}; mem_ready = 1'b1;
    #1;
    checkOutput("stray_ready", {o_i_ready, o_d_ready}, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    checkOutput("stray_busy", o_busy, 0);
    checkOutput("stray_mem_read", o_mem_read, 0);

    // Round-robin instance with both caches requesting back to back.
    sel = 1'b1;
    @(negedge clk);
    applyStimulus(1, 1, 0, 28'h0001000, '0);
    applyStimulus(0, 1, 0, 28'h0002000, '0);
    serveMem(1, 2, {4{32'h11111111}});
    applyStimulus(1, 1, 0, 28'h0003000, '0);
    serveMem(2, 2, {4{32'h22222222}});
    applyStimulus(0, 1, 0, 28'h0004000, '0);
    serveMem(2, 2, {4{32'h33333333}});
    serveMem(2, 2, {4{32'h44444444}});
    @(negedge clk);
    checkOutput("rr_idle_busy", o_busy, 0);
    checkOutput("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
